// File: rtl/htif_mem_pkg.sv
// Shared types and constants for the HTIF memory responder.
// Lines are 128 bits wide, split into eight 16-bit write lanes.
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 8
`endif

package htif_mem_pkg;
  localparam int MEM_TAG_BITS = `MEM_TAG_BITS;
  localparam int LINE_BYTES = 16;
  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int WMASK_BITS = 8;
  localparam int LANE_BITS = LINE_BITS / WMASK_BITS;

  localparam logic HTIF_RW_READ = 1'b0;
  localparam logic HTIF_RW_WRITE = 1'b1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;
endpackage

// File: rtl/htif_mem_array.sv
// Single-port line RAM with 16-bit lane write mask and registered read.
// Replace this module to map onto a technology SRAM macro.
module htif_mem_array
  import htif_mem_pkg::*;
#(
  parameter int ADDR_BITS = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [LINE_BITS-1:0]  wdata,
  input  logic [WMASK_BITS-1:0] wmask,
  output logic [LINE_BITS-1:0]  rdata
);

  logic [LINE_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < WMASK_BITS; i++) begin
        if (wmask[i]) begin
          mem[addr][LANE_BITS*i +: LANE_BITS] <= wdata[LANE_BITS*i +: LANE_BITS];
        end
      end
    end
  end

  // Read register only moves on reads, so it holds across writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/htif_mem_responder.sv
// HTIF memory-side responder: zero-init sweep, lane-masked writes,
// and fixed-latency in-order tagged read responses.
module htif_mem_responder
  import htif_mem_pkg::*;
#(
  parameter int ADDR_BITS = 14,
  parameter int DATA_BITS = 128,
  parameter int TAG_BITS  = MEM_TAG_BITS,
  parameter int LATENCY   = 2,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  htif_req_val,
  output logic                  htif_req_rdy,
  input  logic                  htif_req_rw,
  input  logic [ADDR_BITS-1:0]  htif_req_addr,
  input  logic [DATA_BITS-1:0]  htif_req_data,
  input  logic [WMASK_BITS-1:0] htif_req_wmask,
  input  logic [TAG_BITS-1:0]   htif_req_tag,
  output logic                  htif_resp_val,
  output logic [DATA_BITS-1:0]  htif_resp_data,
  output logic [TAG_BITS-1:0]   htif_resp_tag
);

  if (DATA_BITS != LINE_BITS) begin : g_bad_data
    $error("htif_mem_responder: DATA_BITS must be 128");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_lat
    $error("htif_mem_responder: LATENCY must be 1..4");
  end

  localparam int DW = (LATENCY > 1) ? LATENCY - 1 : 1;

  state_t state, state_nxt;
  logic [ADDR_BITS-1:0] cnt;
  logic fire, rd_fire, in_init;

  logic                  mem_en, mem_we;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [LINE_BITS-1:0]  mem_wdata, mem_rdata;
  logic [WMASK_BITS-1:0] mem_wmask;

  logic [LATENCY-1:0]                vq;
  logic [LATENCY-1:0][TAG_BITS-1:0]  tq;
  logic [DW-1:0][LINE_BITS-1:0]      dq;

  assign in_init = (state == ST_INIT);
  assign htif_req_rdy = (state == ST_RUN) && !reset;
  assign fire = htif_req_val && htif_req_rdy;
  assign rd_fire = fire && (htif_req_rw == HTIF_RW_READ);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: if (cnt == '1) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT_ZERO ? ST_INIT : ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= in_init ? cnt + 1'b1 : '0;
    end
  end

  // The init sweep owns the array port until it reaches ST_RUN.
  always_comb begin
    mem_en    = !reset && (in_init || fire);
    mem_we    = htif_req_rw;
    mem_addr  = htif_req_addr;
    mem_wdata = htif_req_data;
    mem_wmask = htif_req_wmask;
    if (in_init) begin
      mem_we    = HTIF_RW_WRITE;
      mem_addr  = cnt;
      mem_wdata = '0;
      mem_wmask = '1;
    end
  end

  htif_mem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .wmask (mem_wmask),
    .rdata (mem_rdata)
  );

  // Stage 1 data is the array read register; later stages live in dq.
  always_ff @(posedge clk) begin
    if (reset) begin
      vq <= '0;
      tq <= '0;
      dq <= '0;
    end else begin
      vq[0] <= rd_fire;
      if (rd_fire) tq[0] <= htif_req_tag;
      for (int k = 1; k < LATENCY; k++) begin
        vq[k] <= vq[k-1];
        if (vq[k-1]) tq[k] <= tq[k-1];
      end
      if (vq[0]) dq[0] <= mem_rdata;
      for (int k = 1; k < DW; k++) begin
        if (vq[k]) dq[k] <= dq[k-1];
      end
    end
  end

  assign htif_resp_val = vq[LATENCY-1];
  assign htif_resp_tag = tq[LATENCY-1];

  if (LATENCY == 1) begin : g_lat1
    assign htif_resp_data = mem_rdata;
  end else begin : g_latn
    assign htif_resp_data = dq[LATENCY-2];
  end

endmodule

// File: tb/tb_htif_mem_responder.sv
// Randomised self-checking bench for htif_mem_responder against a
// line-array model with an expected-response queue.
module tb_htif_mem_responder;
  import htif_mem_pkg::*;

  localparam int AB  = 6;
  localparam int LAT = 3;
  localparam int TW  = 8;
  localparam int NL  = 2**AB;

  typedef struct packed {
    int             cyc;
    logic [127:0]   data;
    logic [TW-1:0]  tag;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic          req_rw = 1'b0;
  logic [AB-1:0] req_addr = '0;
  logic [127:0]  req_data = '0;
  logic [7:0]    req_wmask = '0;
  logic [TW-1:0] req_tag = '0;
  logic          resp_val;
  logic [127:0]  resp_data;
  logic [TW-1:0] resp_tag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] model [NL];
  rsp_t exp_q[$];
  rsp_t obs_q[$];

  htif_mem_responder #(
    .ADDR_BITS(AB),
    .DATA_BITS(128),
    .TAG_BITS(TW),
    .LATENCY(LAT),
    .INIT_ZERO(1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .htif_req_val   (req_val),
    .htif_req_rdy   (req_rdy),
    .htif_req_rw    (req_rw),
    .htif_req_addr  (req_addr),
    .htif_req_data  (req_data),
    .htif_req_wmask (req_wmask),
    .htif_req_tag   (req_tag),
    .htif_resp_val  (resp_val),
    .htif_resp_data (resp_data),
    .htif_resp_tag  (resp_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_val === 1'b1) obs_q.push_back('{cyc, resp_data, resp_tag});
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < NL; i++) model[i] = '0;
  endtask

  // One request in the current cycle; the model tracks its effect.
  task automatic issue(input logic rw, input logic [AB-1:0] a,
                       input logic [127:0] d, input logic [7:0] m,
                       input logic [TW-1:0] t);
    logic [127:0] lanes;
    lanes = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) lanes = lanes | (128'hFFFF << (16 * i));
    end
    req_val = 1'b1;
    req_rw = rw;
    req_addr = a;
    req_data = d;
    req_wmask = m;
    req_tag = t;
    if (rw) begin
      model[a] = (model[a] & ~lanes) | (d & lanes);
    end else begin
      exp_q.push_back('{cyc + LAT, model[a], t});
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
    req_data = rnd128();
  endtask

  task automatic wait_rdy(input string nm, output int n);
    n = 0;
    while (req_rdy !== 1'b1 && n < 300) begin
      n++;
      @(posedge clk);
      #1;
    end
    if (req_rdy !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: rdy never rose within %0d cycles", nm, n);
    end
  endtask

  task automatic test_reset();
    int n;
    obs_q.delete();
    exp_q.delete();
    reset = 1'b1;
    idle(3);
    checks++;
    if (req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy: got %b want 0", req_rdy);
    end
    checks++;
    if ({resp_val, resp_data, resp_tag} !== '0) begin
      errors++;
      $display("FAIL reset_resp: got val=%b data=%h tag=%h want zeros",
               resp_val, resp_data, resp_tag);
    end
    reset = 1'b0;
    #1;
    wait_rdy("init_len", n);
    checks++;
    if (n != NL) begin
      errors++;
      $display("FAIL init_len: got %0d rdy-low cycles want %0d", n, NL);
    end
    model_zero();
    issue(HTIF_RW_READ, 6'd5, '0, '0, 8'd3);
    idle(LAT + 2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_read count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_read rsp%0d: got cyc=%0d data=%h tag=%h want cyc=%0d data=%h tag=%h",
                 i, obs_q[i].cyc, obs_q[i].data, obs_q[i].tag,
                 exp_q[i].cyc, exp_q[i].data, exp_q[i].tag);
      end
    end
  endtask

  task automatic test_write_read();
    obs_q.delete();
    exp_q.delete();
    issue(HTIF_RW_WRITE, 6'h2A, 128'h0123456789ABCDEF0123456789ABCDEF, 8'hFF, 8'd0);
    issue(HTIF_RW_READ, 6'h2A, rnd128(), 8'h00, 8'd7);
    idle(LAT + 2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wr_rd count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wr_rd rsp%0d: got cyc=%0d data=%h tag=%h want cyc=%0d data=%h tag=%h",
                 i, obs_q[i].cyc, obs_q[i].data, obs_q[i].tag,
                 exp_q[i].cyc, exp_q[i].data, exp_q[i].tag);
      end
    end
  endtask

  task automatic test_partial_write();
    obs_q.delete();
    exp_q.delete();
    issue(HTIF_RW_WRITE, 6'h10, {128{1'b1}}, 8'hFF, 8'd0);
    issue(HTIF_RW_WRITE, 6'h10, '0, 8'h01, 8'd0);
    issue(HTIF_RW_READ, 6'h10, '0, 8'h00, 8'd1);
    issue(HTIF_RW_WRITE, 6'h11, rnd128(), 8'hFF, 8'd0);
    issue(HTIF_RW_WRITE, 6'h11, rnd128(), 8'h00, 8'd0);
    issue(HTIF_RW_WRITE, 6'h12, rnd128(), 8'hFF, 8'd0);
    issue(HTIF_RW_WRITE, 6'h12, rnd128(), 8'hA5, 8'd0);
    issue(HTIF_RW_READ, 6'h11, '0, 8'h00, 8'd2);
    issue(HTIF_RW_READ, 6'h12, '0, 8'h00, 8'd3);
    idle(LAT + 2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL partial count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL partial rsp%0d: got cyc=%0d data=%h tag=%h want cyc=%0d data=%h tag=%h",
                 i, obs_q[i].cyc, obs_q[i].data, obs_q[i].tag,
                 exp_q[i].cyc, exp_q[i].data, exp_q[i].tag);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AB-1:0] a [4];
    a[0] = 6'd20;
    a[1] = 6'd21;
    a[2] = 6'd40;
    a[3] = 6'd63;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) issue(HTIF_RW_WRITE, a[i], rnd128(), 8'hFF, 8'd0);
    idle(2);
    for (int i = 0; i < 4; i++) issue(HTIF_RW_READ, a[i], '0, 8'h00, TW'(i));
    idle(LAT + 2);
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL b2b count: got %0d want 4", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b rsp%0d: got cyc=%0d data=%h tag=%h want cyc=%0d data=%h tag=%h",
                 i, obs_q[i].cyc, obs_q[i].data, obs_q[i].tag,
                 exp_q[i].cyc, exp_q[i].data, exp_q[i].tag);
      end
    end
  endtask

  task automatic test_read_then_write();
    obs_q.delete();
    exp_q.delete();
    issue(HTIF_RW_WRITE, 6'd9, rnd128(), 8'hFF, 8'd0);
    idle(1);
    issue(HTIF_RW_READ, 6'd9, '0, 8'h00, 8'd5);
    issue(HTIF_RW_WRITE, 6'd9, rnd128(), 8'hFF, 8'd0);
    idle(1);
    issue(HTIF_RW_READ, 6'd9, '0, 8'h00, 8'd6);
    idle(LAT + 2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rd_wr count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rd_wr rsp%0d: got cyc=%0d data=%h tag=%h want cyc=%0d data=%h tag=%h",
                 i, obs_q[i].cyc, obs_q[i].data, obs_q[i].tag,
                 exp_q[i].cyc, exp_q[i].data, exp_q[i].tag);
      end
    end
  endtask

  task automatic test_random();
    int r;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        idle(1);
      end else if (r == 1) begin
        issue(HTIF_RW_WRITE, AB'($urandom), rnd128(), 8'($urandom), 8'd0);
      end else begin
        issue(HTIF_RW_READ, AB'($urandom), rnd128(), 8'($urandom), TW'($urandom));
      end
    end
    idle(LAT + 2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random rsp%0d: got cyc=%0d data=%h tag=%h want cyc=%0d data=%h tag=%h",
                 i, obs_q[i].cyc, obs_q[i].data, obs_q[i].tag,
                 exp_q[i].cyc, exp_q[i].data, exp_q[i].tag);
      end
    end
  endtask

  task automatic test_reset_flush();
    int n;
    obs_q.delete();
    exp_q.delete();
    issue(HTIF_RW_WRITE, 6'd30, rnd128(), 8'hFF, 8'd0);
    issue(HTIF_RW_READ, 6'd30, '0, 8'h00, 8'd11);
    issue(HTIF_RW_READ, 6'd31, '0, 8'h00, 8'd12);
    reset = 1'b1;
    #1;
    checks++;
    if (req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL flush_rdy: got %b want 0 during reset", req_rdy);
    end
    idle(1);
    checks++;
    if ({resp_val, resp_data, resp_tag} !== '0) begin
      errors++;
      $display("FAIL flush_resp: got val=%b data=%h tag=%h want zeros",
               resp_val, resp_data, resp_tag);
    end
    reset = 1'b0;
    #1;
    wait_rdy("flush_init", n);
    idle(LAT + 4);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL flush_drop: got %0d responses after reset want 0", obs_q.size());
    end
    model_zero();
    exp_q.delete();
    obs_q.delete();
    issue(HTIF_RW_READ, 6'd30, '0, 8'h00, 8'd13);
    idle(LAT + 2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL flush_read count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL flush_read rsp%0d: got cyc=%0d data=%h tag=%h want cyc=%0d data=%h tag=%h",
                 i, obs_q[i].cyc, obs_q[i].data, obs_q[i].tag,
                 exp_q[i].cyc, exp_q[i].data, exp_q[i].tag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_read_then_write();
    test_random();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
